// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl -- bit-serial add/subtract controller.
//
// Captures two WIDTH-bit operands on an accepted start. It then pushes them
// LSB-first through one NAND-built full adder, one bit per clock, with a
// registered carry loop. The assembled result is published together with a
// one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN
//   defined   -> signed overflow is computed at the final bit
//   undefined -> ovf is tied to 0 and no overflow logic is built
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   sub        0 = A+B, 1 = A-B (captured with start)
//   op_a,op_b  operands (captured with start)
//   busy       high while the serial run is in progress
//   done       one-cycle pulse, result valid
//   result     sum/difference, held until the next run completes
//   carry_out  final carry (for sub: 1 = no borrow)
//   ovf        signed overflow (0 when the macro is undefined)

module full_adder_nand (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic n1, n2, n3, x1, n4, n5, n6;

  assign n1   = ~(a & b);
  assign n2   = ~(a & n1);
  assign n3   = ~(b & n1);
  assign x1   = ~(n2 & n3);   // a ^ b
  assign n4   = ~(x1 & cin);
  assign n5   = ~(x1 & n4);
  assign n6   = ~(cin & n4);
  assign sum  = ~(n5 & n6);   // a ^ b ^ cin
  assign cout = ~(n1 & n4);   // a&b | cin&(a^b)
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] sh_a, sh_b, result_sr;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             fa_sum, fa_cout;
  logic             accept, last_bit;

  full_adder_nand u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (cy),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_bit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last_bit   = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted at capture, the +1 enters
  // through the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a      <= '0;
      sh_b      <= '0;
      result_sr <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      sh_a <= op_a;
      sh_b <= op_b ^ {WIDTH{sub}};
      cy   <= sub;
      cnt  <= '0;
    end else if (state == RUN) begin
      sh_a      <= sh_a >> 1;
      sh_b      <= sh_b >> 1;
      result_sr <= {fa_sum, result_sr[WIDTH-1:1]};
      cy        <= fa_cout;
      cnt       <= cnt + 1'b1;
      if (last_bit) begin
        result    <= {fa_sum, result_sr[WIDTH-1:1]};
        carry_out <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // During the last bit, cy holds the carry into the MSB; ovf is carry-in
  // versus carry-out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ovf <= 1'b0;
    else if (last_bit) ovf <= cy ^ fa_cout;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy, done, carry_out, ovf;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic.
  logic [W-1:0] exp_res;
  logic         exp_cy, exp_ovf;
  logic [W-1:0] prev_res;

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int ia, ib, sa, sb, sr;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    if (s) begin
      exp_res = W'((ia - ib + 256) % 256);
      exp_cy  = (ia >= ib);
      sr      = sa - sb;
    end else begin
      exp_res = W'((ia + ib) % 256);
      exp_cy  = (ia + ib) > 255;
      sr      = sa + sb;
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    exp_ovf = (sr > 127) || (sr < -128);
`else
    exp_ovf = 1'b0;
`endif
  endtask

  // Runs one operation; optionally pulses start with other operands mid-run.
  task automatic do_op(input string name, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s, input bit midstart);
    int cycles, busy_cnt;
    model(a, b, s);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    busy_cnt = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cnt++;
      if (cycles == 3) begin
        checks++;
        if (result !== prev_res) begin
          errors++;
          $display("FAIL %s hold: result=%h required=%h", name, result, prev_res);
        end
      end
      if (midstart && cycles == 2) begin
        start = 1'b1; op_a = ~a; op_b = a; sub = ~s;
      end else begin
        start = 1'b0; op_a = $urandom; op_b = $urandom; sub = $urandom;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checks++;
    if (cycles !== W) begin
      errors++;
      $display("FAIL %s latency: cycles=%0d required=%0d", name, cycles, W);
    end
    checks++;
    if (busy_cnt !== W || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: busy_cycles=%0d busy_at_done=%b required=%0d/0", name, busy_cnt, busy, W);
    end
    checks++;
    if (result !== exp_res || carry_out !== exp_cy || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s value: result=%h cy=%b ovf=%b required=%h %b %b",
               name, result, carry_out, ovf, exp_res, exp_cy, exp_ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse: done=%b busy=%b required=0 0", name, done, busy);
    end
    if (midstart) begin
      for (int i = 0; i < W + 3; i++) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s ghost: done=%b busy=%b required=0 0", name, done, busy);
        end
      end
    end
    prev_res = exp_res;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || carry_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h cy=%b ovf=%b required=0 0 00 0 0",
               busy, done, result, carry_out, ovf);
    end
    prev_res = '0;
  endtask

  task automatic test_directed();
    do_op("add_3c_55", 8'h3C, 8'h55, 1'b0, 1'b0);
    do_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0);
    do_op("sub_20_10", 8'h20, 8'h10, 1'b1, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_midstart();
    do_op("midstart", 8'h5A, 8'h33, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    op_a = 8'hC3; op_b = 8'h21; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      errors++;
      $display("FAIL reset_midrun: busy=%b done=%b result=%h required=0 0 00", busy, done, result);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: done=%b busy=%b required=0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    prev_res = '0;
    do_op("after_reset", 8'h9E, 8'h47, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_midstart();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
